// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, error causes,
// FSM states and the request legality check applied when a request is accepted.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_e;

  // Illegal funct3 wins over misalignment; funct3[1:0] encodes the access size.
  function automatic cause_e check_request(input logic [2:0] funct3, input logic [1:0] off);
    if (funct3 == 3'b011 || funct3[2:1] == 2'b11) return CAUSE_ILLEGAL;
    if (funct3[1:0] == 2'b01 && off[0])           return CAUSE_MISALIGN;
    if (funct3[1:0] == 2'b10 && off != 2'b00)     return CAUSE_MISALIGN;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: req/gnt request phase plus rvalid
// read-return phase. The unit is the master, the memory is the slave.
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_gnt;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: extracts and extends the addressed byte/half of a
// load word, and builds byte enables plus lane-replicated data for a store.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  // Load result: pick the addressed lane, then sign- or zero-extend.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_load = i_rdata;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'b0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'b0, w_half};
      default: o_load = i_rdata;
    endcase
  end

  // Store lanes: byte enables follow the offset, data is replicated to every lane.
  always_comb begin
    o_be    = 4'hF;
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'hF;
        o_wdata = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage engine: accepts one load/store from the pipeline, runs the
// req/gnt + rvalid handshake to data memory and reports completion with o_done.
// Byte enables are driven for loads as well (lanes being read); store data is
// driven only for stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_we,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_err_cause,
  output logic [WIDTH-1:0] o_load_data,
  load_store_unit_if.master mem
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           r_state, w_state_next;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_addr, r_wdata, r_load_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done, r_err;
  cause_e           r_cause;

  logic             w_accept, w_mem_req, w_finish, w_fin_err, w_load_cap, w_timeout;
  cause_e           w_fin_cause, w_req_cause;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata_rep, w_load_ext;

  assign w_req_cause = check_request(i_funct3, i_addr[1:0]);
  // Counter holds the number of REQ/WAIT cycles already spent before this one.
  assign w_timeout   = (r_cnt >= CNT_LAST);

  lsu_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .i_rdata  (mem.mem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata_rep),
    .o_load   (w_load_ext)
  );

  // State register.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state, memory request and completion decode; gnt/rvalid beat the timeout.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mem_req    = 1'b0;
    w_finish     = 1'b0;
    w_fin_err    = 1'b0;
    w_fin_cause  = CAUSE_NONE;
    w_load_cap   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_accept = 1'b1;
          if (w_req_cause != CAUSE_NONE) begin
            w_finish    = 1'b1;
            w_fin_err   = 1'b1;
            w_fin_cause = w_req_cause;
          end else begin
            w_state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_mem_req = 1'b1;
        if (mem.mem_gnt) begin
          if (r_we) begin
            w_finish     = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_WAIT;
          end
        end else if (w_timeout) begin
          w_finish     = 1'b1;
          w_fin_err    = 1'b1;
          w_fin_cause  = CAUSE_TIMEOUT;
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          w_load_cap   = 1'b1;
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_timeout) begin
          w_finish     = 1'b1;
          w_fin_err    = 1'b1;
          w_fin_cause  = CAUSE_TIMEOUT;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture request fields on accept so the memory sees them stable in REQ.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_we     <= i_we;
      r_funct3 <= i_funct3;
      r_addr   <= i_addr;
      r_wdata  <= i_wdata;
    end
  end

  // Timeout counter: cleared on entering REQ, counts every REQ/WAIT cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_cnt <= '0;
    else if (w_accept)          r_cnt <= '0;
    else if (r_state != S_IDLE) r_cnt <= r_cnt + 1'b1;
  end

  // Completion pulse with its error status; load data held until the next load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cause     <= CAUSE_NONE;
      r_load_data <= '0;
    end else begin
      r_done  <= w_finish;
      r_err   <= w_finish & w_fin_err;
      r_cause <= w_finish ? w_fin_cause : CAUSE_NONE;
      if (w_load_cap) r_load_data <= w_load_ext;
    end
  end

  assign o_req_ready   = (r_state == S_IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_err_cause   = r_cause;
  assign o_load_data   = r_load_data;

  assign mem.mem_req   = w_mem_req;
  assign mem.mem_we    = w_mem_req & r_we;
  assign mem.mem_be    = w_mem_req ? w_be : 4'b0000;
  assign mem.mem_addr  = w_mem_req ? {r_addr[WIDTH-1:2], 2'b00} : '0;
  assign mem.mem_wdata = (w_mem_req & r_we) ? w_wdata_rep : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses against a behavioural model of the memory-access rules.
module tb_load_store_unit;

  localparam int TIMEOUT = 12;
  localparam int NEVER   = 1000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_done, o_err;
  logic [1:0]  o_err_cause;
  logic [31:0] o_load_data;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_load = '0;

  load_store_unit_if #(.WIDTH(32)) mem_bus ();

  load_store_unit #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_err_cause (o_err_cause),
    .o_load_data (o_load_data),
    .mem         (mem_bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: shift the addressed lane down to bit 0, then extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> (8 * addr[1:0]);
    case (f3[1:0])
      2'b00:   return f3[2] ? (sh & 32'h0000_00FF) : 32'($signed(sh[7:0]));
      2'b01:   return f3[2] ? (sh & 32'h0000_FFFF) : 32'($signed(sh[15:0]));
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    case (f3[1:0])
      2'b00:   return 4'(1 << addr[1:0]);
      2'b01:   return 4'(3 << addr[1:0]);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return wd[7:0] * 32'h0101_0101;
      2'b01:   return wd[15:0] * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // One access: g = REQ/WAIT cycle index (1-based) carrying gnt, r = index carrying rvalid.
  task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int g, input int r);
    logic [1:0]  exp_cause;
    logic [31:0] exp_ld;
    logic        touches_mem, exp_req;
    int          done_k, c;

    exp_cause = 2'b00;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) exp_cause = 2'b11;
    else if ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00))
      exp_cause = 2'b01;
    touches_mem = (exp_cause == 2'b00);
    exp_ld      = last_load;
    done_k      = 1;
    if (touches_mem) begin
      c = we ? g : r;
      if (c <= TIMEOUT) begin
        done_k = c + 1;
        if (!we) exp_ld = ref_load(f3, addr, rdata);
      end else begin
        done_k    = TIMEOUT + 1;
        exp_cause = 2'b10;
      end
    end

    @(posedge i_clk); #1;
    i_req_valid = 1'b1;
    i_we        = we;
    i_funct3    = f3;
    i_addr      = addr;
    i_wdata     = wdata;
    @(negedge i_clk);
    check({name, ":ready_at_accept"}, 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_we        = ~we;
    i_funct3    = 3'($urandom);
    i_addr      = $urandom;
    i_wdata     = $urandom;

    for (int k = 1; k <= done_k; k++) begin
      mem_bus.mem_gnt    = (k == g);
      mem_bus.mem_rvalid = (k == r) || (k <= g && $urandom_range(0, 1) == 1);
      mem_bus.mem_rdata  = (k == r) ? rdata : $urandom;
      exp_req = touches_mem && k <= g && k <= TIMEOUT;
      @(negedge i_clk);
      check({name, ":mem_req"}, 32'(mem_bus.mem_req), 32'(exp_req));
      check({name, ":done"},    32'(o_done),          32'(k == done_k));
      check({name, ":ready"},   32'(o_req_ready),     32'(k == done_k));
      if (exp_req) begin
        check({name, ":mem_addr"},  mem_bus.mem_addr,       addr & 32'hFFFF_FFFC);
        check({name, ":mem_we"},    32'(mem_bus.mem_we),    32'(we));
        check({name, ":mem_be"},    32'(mem_bus.mem_be),    32'(ref_be(f3, addr)));
        check({name, ":mem_wdata"}, mem_bus.mem_wdata,      we ? ref_wdata(f3, wdata) : 32'h0);
      end else begin
        check({name, ":idle_we"},    32'(mem_bus.mem_we), 32'd0);
        check({name, ":idle_be"},    32'(mem_bus.mem_be), 32'd0);
        check({name, ":idle_wdata"}, mem_bus.mem_wdata,   32'h0);
      end
      if (k == done_k) begin
        check({name, ":err"},       32'(o_err),       32'(exp_cause != 2'b00));
        check({name, ":cause"},     32'(o_err_cause), 32'(exp_cause));
        check({name, ":load_data"}, o_load_data,      exp_ld);
      end
      if (k < done_k) begin
        @(posedge i_clk); #1;
      end
    end
    mem_bus.mem_gnt    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    last_load = exp_ld;
  endtask

  initial begin
    logic        rwe;
    logic [2:0]  rf3;
    int          rg;

    mem_bus.mem_gnt    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = '0;

    // Reset state
    #12;
    check("reset:ready",   32'(o_req_ready),     32'd1);
    check("reset:done",    32'(o_done),          32'd0);
    check("reset:err",     32'(o_err),           32'd0);
    check("reset:cause",   32'(o_err_cause),     32'd0);
    check("reset:ld",      o_load_data,          32'h0);
    check("reset:mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("reset:addr",    mem_bus.mem_addr,     32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Directed loads/stores with the nominal gnt T+1 / rvalid T+2 timing
    run_access("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1, 2);
    run_access("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 1, 2);
    run_access("lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 2);
    run_access("sb_201",  1'b1, 3'b000, 32'h201, 32'hAB, 32'h0, 1, NEVER);
    run_access("sh_302",  1'b1, 3'b001, 32'h302, 32'h1234_5678, 32'h0, 2, NEVER);
    run_access("lh_neg",  1'b0, 3'b001, 32'h0, 32'h0, 32'h0000_9ABC, 3, 5);

    // Errors decided at accept
    run_access("lw_mis",  1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 2);
    run_access("sh_mis",  1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 1, 2);
    run_access("ill_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 2);
    run_access("ill_pri", 1'b0, 3'b110, 32'h101, 32'h0, 32'h0, 1, 2);

    // Timeouts and their boundaries
    run_access("to_load",  1'b0, 3'b010, 32'h400, 32'h0, 32'h1111_2222, 1, NEVER);
    for (int i = 0; i < 2; i++) begin
      @(posedge i_clk); #1;
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = $urandom;
      @(negedge i_clk);
      check("late_rvalid:done", 32'(o_done), 32'd0);
      check("late_rvalid:ld",   o_load_data, last_load);
    end
    mem_bus.mem_rvalid = 1'b0;
    run_access("to_store", 1'b1, 3'b010, 32'h404, 32'h5555_AAAA, 32'h0, NEVER, NEVER);
    run_access("gnt_edge", 1'b1, 3'b000, 32'h405, 32'h77, 32'h0, TIMEOUT, NEVER);
    run_access("rv_edge",  1'b0, 3'b100, 32'h406, 32'h0, 32'h00C3_0000, 2, TIMEOUT);

    // Reset while waiting for rvalid
    @(posedge i_clk); #1;
    i_req_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h300;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    @(posedge i_clk); #1;
    mem_bus.mem_gnt = 1'b0;
    #1;
    i_rst = 1'b1;
    #1;
    check("rst_wait:mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_wait:ready",   32'(o_req_ready),     32'd1);
    @(negedge i_clk);
    check("rst_wait:done",    32'(o_done),          32'd0);
    check("rst_wait:ld",      o_load_data,          32'h0);
    last_load = '0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'hFEED_F00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      check("rst_late:done", 32'(o_done), 32'd0);
      check("rst_late:ld",   o_load_data, 32'h0);
      @(posedge i_clk); #1;
    end
    mem_bus.mem_rvalid = 1'b0;
    run_access("after_rst", 1'b0, 3'b001, 32'h502, 32'h0, 32'h8765_4321, 1, 2);

    // Randomized accesses within the timeout window
    for (int i = 0; i < 40; i++) begin
      rwe = 1'($urandom);
      rf3 = 3'($urandom);
      rg  = $urandom_range(1, 4);
      run_access("rand", rwe, rf3, $urandom, $urandom, $urandom, rg, rg + $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
